// File: rtl/csr_arb_pkg.sv
// Shared types and constants for the CSR bus arbiter / sequencer.
package csr_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Widest address / operand the owner register can hold; top parameters must not exceed these.
  localparam int unsigned CSR_MAX_ADDR_W = 64;
  localparam int unsigned CSR_MAX_REG_W  = 64;

  localparam logic [2:0] EXC_TIMEOUT = 3'b101;

  localparam int unsigned CORE = 0;
  localparam int unsigned DBG  = 1;

  typedef struct packed {
    logic [1:0]                op;
    logic [2:0]                funct3;
    logic [4:0]                imm;
    logic [CSR_MAX_REG_W-1:0]  rs1_val;
    logic [CSR_MAX_ADDR_W-1:0] addr;
  } csr_req_t;

  function automatic logic [1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/csr_rr_arb.sv
// Two-way round-robin grant; priority pointer moves to the other requester on each grant.
module csr_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] grant_c
);

  // 0: core has priority, 1: debug has priority
  logic ptr_q;

  always_comb begin
    grant_c = 2'b00;
    if (req[0] && (!req[1] || !ptr_q)) begin
      grant_c = 2'b01;
    end else if (req[1]) begin
      grant_c = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (upd && (grant_c != 2'b00)) begin
      ptr_q <= grant_c[0];
    end
  end

endmodule

// File: rtl/csr_bus_arb.sv
// Shares the CSR bus between core and debug, sequencing one access at a time with a
// response timeout so an unmapped address always terminates with an exception.
module csr_bus_arb
  import csr_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 rq_vld,
  output logic [1:0]                 rq_rdy,
  input  logic [1:0][1:0]            rq_op,
  input  logic [1:0][2:0]            rq_funct3,
  input  logic [1:0][4:0]            rq_imm,
  input  logic [1:0][REG_WIDTH-1:0]  rq_rs1_val,
  input  logic [1:0][ADDR_WIDTH-1:0] rq_addr,
  output logic [1:0]                 rs_vld,
  output logic [ADDR_WIDTH-1:0]      rs_rdata,
  output logic [2:0]                 rs_exc,
  output logic                       csr_valid,
  output logic [1:0]                 csr_op,
  output logic [2:0]                 csr_funct3,
  output logic [4:0]                 csr_imm,
  output logic [REG_WIDTH-1:0]       rs1_val,
  output logic [ADDR_WIDTH-1:0]      csr_addr,
  output logic                       csr_rrsp,
  input  logic [ADDR_WIDTH-1:0]      csr_rdata,
  input  logic                       csr_rvalid,
  input  logic [2:0]                 csr_reg_rsp
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  csr_req_t              own_q, own_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] rs_rdata_d;
  logic [2:0]            rs_exc_d;
  logic [1:0]            rs_vld_d;
  logic                  csr_valid_d;
  logic                  csr_rrsp_d;
  logic                  arb_en;
  logic [1:0]            grant_c;
  logic                  gidx;

  // Arbitration only in IDLE; a grant coinciding with reset is discarded, so hide it.
  assign arb_en = (state_q == ST_IDLE) && !rst;
  assign gidx   = grant_c[1];
  assign rq_rdy = grant_c;

  csr_rr_arb u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rq_vld & {2{arb_en}}),
    .upd     (arb_en),
    .grant_c (grant_c)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_d      = own_q;
    owner_d    = owner_q;
    rs_rdata_d = rs_rdata;
    rs_exc_d   = rs_exc;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        own_d = '0;
        if (grant_c != 2'b00) begin
          owner_d        = gidx;
          own_d.op       = rq_op[gidx];
          own_d.funct3   = rq_funct3[gidx];
          own_d.imm      = rq_imm[gidx];
          own_d.rs1_val  = CSR_MAX_REG_W'(rq_rs1_val[gidx]);
          own_d.addr     = CSR_MAX_ADDR_W'(rq_addr[gidx]);
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = CNT_W'(1);
        if (csr_rvalid) begin
          rs_rdata_d = csr_rdata;
          rs_exc_d   = csr_reg_rsp;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A bus response in the final window cycle takes precedence over the timeout.
        if (csr_rvalid) begin
          rs_rdata_d = csr_rdata;
          rs_exc_d   = csr_reg_rsp;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rs_rdata_d = '0;
          rs_exc_d   = EXC_TIMEOUT;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        own_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    csr_valid_d = (state_d == ST_ISSUE);
    csr_rrsp_d  = (state_d == ST_RESP);
    rs_vld_d    = (state_d == ST_RESP) ? idx_onehot(owner_d) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      own_q     <= '0;
      owner_q   <= 1'b0;
      rs_rdata  <= '0;
      rs_exc    <= '0;
      rs_vld    <= 2'b00;
      csr_valid <= 1'b0;
      csr_rrsp  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      own_q     <= own_d;
      owner_q   <= owner_d;
      rs_rdata  <= rs_rdata_d;
      rs_exc    <= rs_exc_d;
      rs_vld    <= rs_vld_d;
      csr_valid <= csr_valid_d;
      csr_rrsp  <= csr_rrsp_d;
    end
  end

  assign csr_op     = own_q.op;
  assign csr_funct3 = own_q.funct3;
  assign csr_imm    = own_q.imm;
  assign rs1_val    = REG_WIDTH'(own_q.rs1_val);
  assign csr_addr   = ADDR_WIDTH'(own_q.addr);

endmodule
